// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port sync data RAM between the CPU (m0) and a loader (m1),
// steering one-cycle-delayed read data back to whichever requester issued the read.
module dmem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WAIT  = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [3:0]        m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_stall,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic [3:0]        m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              ram_ena,
    output logic [3:0]        ram_wea,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_dina,
    input  logic [31:0]       ram_douta,
    output logic              err
);
    localparam logic [3:0] MW = 4'(MAX_WAIT);

    logic [3:0]  age_q, age_d;
    logic        ptr_q, ptr_d, pend_q, pend_d, own_q, own_d, oor_q, oor_d, err_q, err_d;
    logic        any_req, sel1, oor;
    logic [31:0] addr;
    logic [3:0]  we;

    always_comb begin
        any_req   = rst_n & (m0_req | m1_req);
        // m1 takes the slot when alone, or when its turn/aging threshold says so
        sel1      = m1_req & (~m0_req | ((PRIO_MODE != 0) ? ptr_q : (age_q == MW)));
        addr      = sel1 ? m1_addr : m0_addr;
        we        = sel1 ? m1_we : m0_we;
        oor       = |addr[31:ADDR_W];
        m0_gnt    = any_req & ~sel1;
        m1_gnt    = any_req & sel1;
        m0_stall  = m0_req & ~m0_gnt;
        ram_ena   = any_req & ~oor;
        ram_wea   = ram_ena ? we : 4'd0;
        ram_addr  = addr[ADDR_W-1:0];
        ram_dina  = sel1 ? m1_wdata : m0_wdata;
        age_d     = (m1_req & ~m1_gnt) ? ((age_q == MW) ? age_q : age_q + 4'd1) : 4'd0;
        ptr_d     = any_req ? ~sel1 : ptr_q;
        pend_d    = any_req & ~|we;
        own_d     = sel1;
        oor_d     = oor;
        err_d     = any_req & oor;
        m0_rvalid = pend_q & ~own_q;
        m1_rvalid = pend_q & own_q;
        m0_rdata  = (m0_rvalid & ~oor_q) ? ram_douta : 32'd0;
        m1_rdata  = (m1_rvalid & ~oor_q) ? ram_douta : 32'd0;
        err       = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q  <= 4'd0;
            ptr_q  <= 1'b0;
            pend_q <= 1'b0;
            own_q  <= 1'b0;
            oor_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            age_q  <= age_d;
            ptr_q  <= ptr_d;
            pend_q <= pend_d;
            own_q  <= own_d;
            oor_q  <= oor_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: two arbiters (priority+aging, round-robin) on shared stimulus, each with its
// own RAM, checked cycle by cycle against a behavioural model with a shadow memory.
module tb_dmem_arbiter;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0, rst_n, ram_clr;
    logic        m0_req, m1_req;
    logic [3:0]  m0_we, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [1:0]  m0_gnt, m0_stall, m0_rvalid, m1_gnt, m1_rvalid, ram_ena, err;
    logic [31:0] m0_rdata[2], m1_rdata[2], ram_dina[2], ram_douta[2];
    logic [3:0]  ram_wea[2];
    logic [9:0]  ram_addr[2];
    logic [31:0] ram_mem[2][1024];

    int          n_chk = 0, n_fail = 0;
    int          age[2];
    bit          ptr[2], pv[2], pown[2], perr[2];
    logic [31:0] pdat[2];
    logic [31:0] shadow[2][1024];
    logic [9:0]  seq0 = '0, seq1 = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(10), .MAX_WAIT(MAX_WAIT), .PRIO_MODE(0)) u_pri (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt[0]), .m0_stall(m0_stall[0]), .m0_rvalid(m0_rvalid[0]), .m0_rdata(m0_rdata[0]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt[0]), .m1_rvalid(m1_rvalid[0]), .m1_rdata(m1_rdata[0]),
        .ram_ena(ram_ena[0]), .ram_wea(ram_wea[0]), .ram_addr(ram_addr[0]),
        .ram_dina(ram_dina[0]), .ram_douta(ram_douta[0]), .err(err[0])
    );

    dmem_arbiter #(.ADDR_W(10), .MAX_WAIT(MAX_WAIT), .PRIO_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt[1]), .m0_stall(m0_stall[1]), .m0_rvalid(m0_rvalid[1]), .m0_rdata(m0_rdata[1]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt[1]), .m1_rvalid(m1_rvalid[1]), .m1_rdata(m1_rdata[1]),
        .ram_ena(ram_ena[1]), .ram_wea(ram_wea[1]), .ram_addr(ram_addr[1]),
        .ram_dina(ram_dina[1]), .ram_douta(ram_douta[1]), .err(err[1])
    );

    function automatic logic [31:0] init_word(int i);
        return (i == 16) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(i));
    endfunction

    // read-first synchronous RAM per arbiter, driven by the DUT's RAM port
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_clr) begin
                for (int i = 0; i < 1024; i++) ram_mem[k][i] <= init_word(i);
            end else if (ram_ena[k]) begin
                ram_douta[k] <= ram_mem[k][ram_addr[k]];
                for (int b = 0; b < 4; b++)
                    if (ram_wea[k][b]) ram_mem[k][ram_addr[k]][8*b +: 8] <= ram_dina[k][8*b +: 8];
            end
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            age[k] = 0; ptr[k] = 0; pv[k] = 0; pown[k] = 0; perr[k] = 0; pdat[k] = '0;
        end
    endtask

    task automatic set_in(bit r0, logic [3:0] w0, logic [31:0] a0, logic [31:0] d0,
                          bit r1, logic [3:0] w1, logic [31:0] a1, logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    // called at a negedge with inputs set; checks this cycle, advances the model over the posedge
    task automatic cyc();
        bit          any, w1, oor, ena;
        logic [31:0] a, d, rd0, rd1;
        logic [3:0]  we;
        int          n_age[2];
        bit          n_ptr[2], n_pv[2], n_own[2], n_err[2], wr[2];
        logic [31:0] n_dat[2], wd[2];
        logic [9:0]  wa[2];
        logic [3:0]  wwe[2];
        #2;
        if (!rst_n) model_reset();
        for (int k = 0; k < 2; k++) begin
            any = rst_n && (m0_req || m1_req);
            w1  = any && m1_req && (!m0_req || (k == 0 ? age[k] == MAX_WAIT : ptr[k]));
            a   = w1 ? m1_addr : m0_addr;
            we  = w1 ? m1_we : m0_we;
            d   = w1 ? m1_wdata : m0_wdata;
            oor = a[31:10] != 0;
            ena = any && !oor;
            rd0 = (pv[k] && !pown[k]) ? pdat[k] : 32'd0;
            rd1 = (pv[k] && pown[k]) ? pdat[k] : 32'd0;
            chk($sformatf("m0_gnt%0d", k), 32'(m0_gnt[k]), 32'(any && !w1));
            chk($sformatf("m1_gnt%0d", k), 32'(m1_gnt[k]), 32'(any && w1));
            chk($sformatf("stall%0d", k), 32'(m0_stall[k]), 32'(m0_req && !(any && !w1)));
            chk($sformatf("ram_ena%0d", k), 32'(ram_ena[k]), 32'(ena));
            chk($sformatf("ram_wea%0d", k), 32'(ram_wea[k]), 32'(ena ? we : 4'd0));
            if (any) begin
                chk($sformatf("ram_addr%0d", k), 32'(ram_addr[k]), 32'(a[9:0]));
                chk($sformatf("ram_dina%0d", k), ram_dina[k], d);
            end
            chk($sformatf("m0_rvalid%0d", k), 32'(m0_rvalid[k]), 32'(pv[k] && !pown[k]));
            chk($sformatf("m1_rvalid%0d", k), 32'(m1_rvalid[k]), 32'(pv[k] && pown[k]));
            chk($sformatf("m0_rdata%0d", k), m0_rdata[k], rd0);
            chk($sformatf("m1_rdata%0d", k), m1_rdata[k], rd1);
            chk($sformatf("err%0d", k), 32'(err[k]), 32'(perr[k]));
            n_age[k] = (m1_req && !(any && w1)) ? ((age[k] >= MAX_WAIT) ? MAX_WAIT : age[k] + 1) : 0;
            n_ptr[k] = any ? !w1 : ptr[k];
            n_pv[k]  = any && we == 4'd0;
            n_own[k] = w1;
            n_err[k] = any && oor;
            n_dat[k] = oor ? 32'd0 : shadow[k][a[9:0]];
            wr[k]  = ena && we != 4'd0;
            wa[k]  = a[9:0];
            wwe[k] = we;
            wd[k]  = d;
        end
        seq0 = {seq0[8:0], m1_gnt[0]};
        seq1 = {seq1[8:0], m1_gnt[1]};
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                age[k] = n_age[k]; ptr[k] = n_ptr[k]; pv[k] = n_pv[k];
                pown[k] = n_own[k]; perr[k] = n_err[k]; pdat[k] = n_dat[k];
                if (wr[k])
                    for (int b = 0; b < 4; b++)
                        if (wwe[k][b]) shadow[k][wa[k]][8*b +: 8] = wd[k][8*b +: 8];
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [3:0] rnd_we();
        return ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    endfunction

    function automatic logic [31:0] rnd_addr();
        int r = $urandom_range(0, 15);
        if (r == 0) return 32'h400 | 32'($urandom_range(0, 63));
        if (r == 1) return 32'h8000_0000 | 32'($urandom_range(0, 1023));
        if (r == 2) return 32'($urandom_range(0, 1023));
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ram_clr = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 1024; i++) shadow[k][i] = init_word(i);
        model_reset();
        cyc();
        cyc();
        ram_clr = 1'b0;
        rst_n = 1'b1;

        set_in(1, 0, 32'h10, 0, 0, 0, 0, 0);
        cyc();
        chk("rd_data", m0_rdata[0], 32'hDEADBEEF);
        chk("rd_valid", 32'(m0_rvalid[0]), 32'd1);
        chk("rd_other", 32'(m1_rvalid[0]), 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();

        set_in(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        repeat (10) cyc();
        chk("age_pattern", 32'(seq0), 32'(10'b0000100001));
        chk("rr_pattern", 32'(seq1), 32'(10'b1010101010));

        set_in(0, 0, 0, 0, 1, 4'b0011, 32'h20, 32'h12345678);
        cyc();
        set_in(1, 0, 32'h20, 0, 0, 0, 0, 0);
        cyc();
        chk("hw_merge", m0_rdata[0], 32'hA5A55678);

        set_in(1, 0, 32'h400, 0, 0, 0, 0, 0);
        cyc();
        chk("oor_err", 32'(err[0]), 32'd1);
        chk("oor_rvalid", 32'(m0_rvalid[0]), 32'd1);
        chk("oor_rdata", m0_rdata[0], 32'd0);

        set_in(0, 0, 0, 0, 1, 0, 32'h8, 0);
        #2;
        chk("rst_pre_gnt", 32'(m1_gnt[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_gnt", 32'({m0_gnt[k], m1_gnt[k], m0_stall[k]}), 32'd0);
            chk("rst_ram", 32'({ram_ena[k], ram_wea[k]}), 32'd0);
            chk("rst_rsp", 32'({m0_rvalid[k], m1_rvalid[k], err[k]}), 32'd0);
            chk("rst_rdata", m0_rdata[k] | m1_rdata[k], 32'd0);
        end
        model_reset();
        @(negedge clk);
        cyc();
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("no_rvalid_after_rst", 32'(m1_rvalid), 32'd0);
        cyc();

        repeat (400) begin
            set_in($urandom_range(0, 3) != 0, rnd_we(), rnd_addr(), $urandom,
                   $urandom_range(0, 3) != 0, rnd_we(), rnd_addr(), $urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port synchronous data RAM (ena, 4-bit byte write enable, address, write data, read data) between two requesters. Requester 0 is the CPU data port (dce/daddr/we/din/dm). Requester 1 is a debug/DMA loader. The block grants one access per cycle, tracks which requester owns the one-cycle-delayed read return, and steers read data back to it. It raises a stall to the CPU when the CPU loses arbitration and prevents starvation of either side.

Parameters:
ADDR_W, 10, RAM address width; bits [ADDR_W-1:0] of the requester address drive the RAM.
MAX_WAIT, 4, consecutive denied cycles after which requester 1 is forced ahead of the CPU (PRIO_MODE=0 only); range 1..15.
PRIO_MODE, 0, 0 = CPU priority with aging; 1 = strict round-robin.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  CPU access request (dce)
m0_we  in  4  CPU byte write enables; 0 = read
m0_addr  in  32  CPU byte address
m0_wdata  in  32  CPU write data
m0_gnt  out  1  CPU access accepted this cycle
m0_stall  out  1  m0_req & ~m0_gnt
m0_rvalid  out  1  CPU read data valid
m0_rdata  out  32  CPU read data
m1_req  in  1  loader request
m1_we  in  4  loader byte write enables
m1_addr  in  32  loader byte address
m1_wdata  in  32  loader write data
m1_gnt  out  1  loader access accepted this cycle
m1_rvalid  out  1  loader read data valid
m1_rdata  out  32  loader read data
ram_ena  out  1  RAM enable
ram_wea  out  4  RAM byte write enables
ram_addr  out  ADDR_W  RAM address
ram_dina  out  32  RAM write data
ram_douta  in  32  RAM read data, valid the cycle after the read
err  out  1  one-cycle pulse: granted address out of range

Behaviour:
- Reset (async, rst_n=0): rvalid regs 0, pending-owner/pending-valid 0, aging counter 0, round-robin pointer = m0, err 0. While rst_n=0: gnt outputs 0, ram_ena 0.
- Grant is combinational from the current requests and the registered arbitration state. At most one gnt per cycle. With no requests, gnt=0 and ram_ena=0.
- PRIO_MODE=0:
  - m0 wins unless aging counter == MAX_WAIT.
  - Counter increments each cycle m1_req=1 and m1 is not granted.
  - Counter clears when m1 is granted or m1_req=0.
  - Counter saturates at MAX_WAIT.
- PRIO_MODE=1:
  - Pointer names the preferred requester.
  - After any grant, the pointer moves to the other requester.
  - A lone requester is always granted.
- Granted access: ram_ena=1, ram_wea/ram_dina/ram_addr taken from the winner. Address bits [ADDR_W-1:0] pass unchanged.
- Out of range (any bit of addr[31:ADDR_W] set):
  - Still granted; ram_ena=0 and ram_wea=0.
  - err pulses the next cycle.
  - A read returns rvalid with rdata=0.
- Read latency: a read granted in cycle N gives mX_rvalid=1 in cycle N+1, with mX_rdata=ram_douta, for one cycle.
  - Owner is registered at grant.
  - Writes produce no rvalid.
  - The non-owner rdata is 0.
- Back-to-back reads from alternating requesters each return to their own owner in the following cycle. No bubbles are required.
- Simultaneous write from one requester and read from the other: only the winner proceeds. The loser holds its request; requesters must keep req/addr/we/wdata stable until gnt.
- Reset asserted while a read is pending: the response is dropped and no rvalid appears after reset release.

Test Plan:
- m0 read addr 0x10 alone, RAM holds 0xDEADBEEF -> m0_gnt=1 cycle N, m0_rvalid=1 and m0_rdata=0xDEADBEEF cycle N+1, m1_rvalid=0.
- Both request continuously, PRIO_MODE=0, MAX_WAIT=4 -> m0 granted 4 cycles, m1 granted in the 5th, m0_stall=1 that cycle only, pattern repeats.
- PRIO_MODE=1, both request continuously -> grants alternate m0,m1,m0,m1.
- m1 write 0x12345678 we=4'b0011 to 0x20, then m0 read 0x20 -> ram_wea=4'b0011 for the write; the read returns the updated low half-word at byte offset 0.
- m0 read addr 0x0000_0400 (ADDR_W=10) -> m0_gnt=1, ram_ena=0, next cycle err=1, m0_rvalid=1, m0_rdata=0.
- m1 read granted, rst_n pulled low the same cycle and released 2 cycles later -> no m1_rvalid at any point; all outputs 0 during reset.
